// File: rtl/grey_1000_reader.sv
// grey_1000_reader
//
// Synchronous reader for a free-running, ripple-clocked 3-digit Johnson decade
// counter. It brings the three 5-bit digit buses into i_clk through a multi-flop
// synchroniser and takes a snapshot when a sample is requested. The snapshot is
// re-compared with the live synchronised value until two consecutive samples
// agree, or until the retry budget runs out. It then decodes the snapshot to BCD
// and binary and reports the result with a one-cycle acknowledge.
//
// Optional feature: define AUTO_SAMPLE_EN to add an internal request generator
// that fires once every P_AUTO_PERIOD cycles and is ORed with i_req.
//
// Ports:
//   i_clk   system clock; every flop uses the rising edge
//   i_rst   synchronous reset, active-low
//   i_100   hundreds digit Johnson code (asynchronous domain)
//   i_010   tens digit Johnson code (asynchronous domain)
//   i_001   units digit Johnson code (asynchronous domain)
//   i_req   sample request, sampled only in IDLE
//   o_busy  high while a capture is in progress (CAP or DEC)
//   o_ack   one-cycle pulse when the result registers are updated
//   o_bcd   {hundreds, tens, units} in BCD
//   o_bin   binary value 0..999
//   o_err   the last capture failed (input unstable or illegal code)

module grey_1000_reader #(
   parameter int unsigned P_SYNC_STAGES = 2,
   parameter int unsigned P_MAX_RETRY   = 3,
   parameter int unsigned P_AUTO_PERIOD = 1000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [4:0]  i_100,
   input  logic [4:0]  i_010,
   input  logic [4:0]  i_001,
   input  logic        i_req,
   output logic        o_busy,
   output logic        o_ack,
   output logic [11:0] o_bcd,
   output logic [9:0]  o_bin,
   output logic        o_err
);

   localparam int unsigned RetryW = (P_MAX_RETRY > 1) ? $clog2(P_MAX_RETRY) : 1;
   localparam logic [RetryW-1:0] RetryLast = RetryW'(P_MAX_RETRY - 1);

   typedef enum logic [1:0] {StIdle, StCap, StDec} state_e;

   // Johnson code -> {legal, bcd}.
   function automatic logic [4:0] dec_digit(input logic [4:0] code);
      logic [4:0] res;
      case (code)
         5'b00000: res = {1'b1, 4'd0};
         5'b00001: res = {1'b1, 4'd1};
         5'b00011: res = {1'b1, 4'd2};
         5'b00111: res = {1'b1, 4'd3};
         5'b01111: res = {1'b1, 4'd4};
         5'b11111: res = {1'b1, 4'd5};
         5'b11110: res = {1'b1, 4'd6};
         5'b11100: res = {1'b1, 4'd7};
         5'b11000: res = {1'b1, 4'd8};
         5'b10000: res = {1'b1, 4'd9};
         default:  res = {1'b0, 4'd0};
      endcase
      return res;
   endfunction

   // ------------------------------------------------------------------------
   // Synchroniser: P_SYNC_STAGES flops per bit, always running.
   // ------------------------------------------------------------------------
   logic [14:0] sync_q [P_SYNC_STAGES];
   logic [14:0] sync_d [P_SYNC_STAGES];
   logic [14:0] sync;

   always_comb begin
      sync_d[0] = {i_100, i_010, i_001};
      for (int s = 1; s < int'(P_SYNC_STAGES); s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         for (int s = 0; s < int'(P_SYNC_STAGES); s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < int'(P_SYNC_STAGES); s++) begin
            sync_q[s] <= sync_d[s];
         end
      end
   end

   assign sync = sync_q[P_SYNC_STAGES-1];

   // ------------------------------------------------------------------------
   // Request source
   // ------------------------------------------------------------------------
   logic req;

`ifdef AUTO_SAMPLE_EN
   localparam int unsigned AutoW = (P_AUTO_PERIOD > 1) ? $clog2(P_AUTO_PERIOD) : 1;

   logic [AutoW-1:0] auto_cnt_q, auto_cnt_d;
   logic             auto_pulse;

   always_comb begin
      auto_pulse = (auto_cnt_q == AutoW'(P_AUTO_PERIOD - 1));
      auto_cnt_d = auto_pulse ? '0 : auto_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         auto_cnt_q <= '0;
      end else begin
         auto_cnt_q <= auto_cnt_d;
      end
   end

   // A pulse arriving while busy is simply not seen by the FSM (IDLE-only sampling).
   assign req = i_req | auto_pulse;
`else
   logic [31:0] unused_auto_period;
   assign unused_auto_period = P_AUTO_PERIOD;
   assign req = i_req;
`endif

   // ------------------------------------------------------------------------
   // Snapshot decode (purely combinational from A)
   // ------------------------------------------------------------------------
   logic [14:0] a_q, a_d;
   logic [4:0]  dec_h, dec_t, dec_u;
   logic        a_legal;
   logic [11:0] a_bcd;
   logic [9:0]  h10, t10, u10, a_bin;

   always_comb begin
      dec_h   = dec_digit(a_q[14:10]);
      dec_t   = dec_digit(a_q[9:5]);
      dec_u   = dec_digit(a_q[4:0]);
      a_legal = dec_h[4] & dec_t[4] & dec_u[4];
      a_bcd   = {dec_h[3:0], dec_t[3:0], dec_u[3:0]};
      h10     = {6'd0, dec_h[3:0]};
      t10     = {6'd0, dec_t[3:0]};
      u10     = {6'd0, dec_u[3:0]};
      // 100h = 64h + 32h + 4h, 10t = 8t + 2t; max 999 fits in 10 bits.
      a_bin   = (h10 << 6) + (h10 << 5) + (h10 << 2) + (t10 << 3) + (t10 << 1) + u10;
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   state_e state_q, state_d;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   logic [RetryW-1:0] retry_q, retry_d;
   logic              sync_match;

   assign sync_match = (sync == a_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (req) state_d = StCap;
         StCap:  if (sync_match || (retry_q == RetryLast)) state_d = StDec;
         StDec:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs and datapath next values
   // ------------------------------------------------------------------------
   logic        unstable_q, unstable_d;
   logic        busy_q, busy_d;
   logic        ack_q, ack_d;
   logic [11:0] bcd_q, bcd_d;
   logic [9:0]  bin_q, bin_d;
   logic        err_q, err_d;

   always_comb begin
      a_d        = a_q;
      retry_d    = retry_q;
      unstable_d = unstable_q;
      bcd_d      = bcd_q;
      bin_d      = bin_q;
      err_d      = err_q;
      ack_d      = 1'b0;
      busy_d     = (state_d != StIdle);
      unique case (state_q)
         StIdle: begin
            if (req) begin
               a_d        = sync;
               retry_d    = '0;
               unstable_d = 1'b0;
            end
         end
         StCap: begin
            if (!sync_match) begin
               if (retry_q == RetryLast) begin
                  unstable_d = 1'b1;
               end else begin
                  a_d     = sync;
                  retry_d = retry_q + 1'b1;
               end
            end
         end
         StDec: begin
            ack_d = 1'b1;
            if (unstable_q || !a_legal) begin
               // Keep the last good result visible; only flag the failure.
               err_d = 1'b1;
            end else begin
               bcd_d = a_bcd;
               bin_d = a_bin;
               err_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         a_q        <= '0;
         retry_q    <= '0;
         unstable_q <= 1'b0;
         busy_q     <= 1'b0;
         ack_q      <= 1'b0;
         bcd_q      <= '0;
         bin_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         a_q        <= a_d;
         retry_q    <= retry_d;
         unstable_q <= unstable_d;
         busy_q     <= busy_d;
         ack_q      <= ack_d;
         bcd_q      <= bcd_d;
         bin_q      <= bin_d;
         err_q      <= err_d;
      end
   end

   assign o_busy = busy_q;
   assign o_ack  = ack_q;
   assign o_bcd  = bcd_q;
   assign o_bin  = bin_q;
   assign o_err  = err_q;

endmodule

// File: tb/tb_grey_1000_reader.sv
// Testbench for grey_1000_reader: directed scenarios plus randomized captures
// checked against a digit-table reference model.

module tb_grey_1000_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  d100, d010, d001;
   logic        req;
   logic        busy, ack, err;
   logic [11:0] bcd;
   logic [9:0]  bin;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [11:0] exp_bcd;
   logic [9:0]  exp_bin;
   logic        exp_err;

   localparam logic [4:0] CODES [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                         5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

   grey_1000_reader #(
      .P_SYNC_STAGES(2),
      .P_MAX_RETRY  (3),
      .P_AUTO_PERIOD(8)
   ) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .i_100 (d100),
      .i_010 (d010),
      .i_001 (d001),
      .i_req (req),
      .o_busy(busy),
      .o_ack (ack),
      .o_bcd (bcd),
      .o_bin (bin),
      .o_err (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Value of a digit code from the table, -1 when illegal.
   function automatic int code_val(input logic [4:0] c);
      for (int i = 0; i < 10; i++) begin
         if (CODES[i] == c) return i;
      end
      return -1;
   endfunction

   function automatic logic [4:0] rand_illegal();
      logic [4:0] c;
      c = 5'($urandom_range(0, 31));
      while (code_val(c) >= 0) c = 5'($urandom_range(0, 31));
      return c;
   endfunction

   task automatic model_update(input logic [4:0] h, input logic [4:0] t, input logic [4:0] u);
      int vh, vt, vu;
      vh = code_val(h);
      vt = code_val(t);
      vu = code_val(u);
      if (vh < 0 || vt < 0 || vu < 0) begin
         exp_err = 1'b1;
      end else begin
         exp_bcd = {4'(vh), 4'(vt), 4'(vu)};
         exp_bin = 10'(vh * 100 + vt * 10 + vu);
         exp_err = 1'b0;
      end
   endtask

   // Drive stable digits, pulse req, and check the full handshake timeline.
   task automatic do_capture(input string name, input logic [4:0] h, input logic [4:0] t,
                             input logic [4:0] u);
      d100 = h;
      d010 = t;
      d001 = u;
      repeat (4) tick();
      req = 1'b1;
      tick();  // edge k
      req = 1'b0;
      checks++;
      if (busy !== 1'b1 || ack !== 1'b0) begin
         errors++;
         $display("FAIL %s k: busy=%b ack=%b required busy=1 ack=0", name, busy, ack);
      end
      tick();  // edge k+1
      checks++;
      if (busy !== 1'b1 || ack !== 1'b0) begin
         errors++;
         $display("FAIL %s k+1: busy=%b ack=%b required busy=1 ack=0", name, busy, ack);
      end
      tick();  // edge k+2
      model_update(h, t, u);
      checks++;
      if (ack !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s k+2: ack=%b busy=%b required ack=1 busy=0", name, ack, busy);
      end
      checks++;
      if (bcd !== exp_bcd || bin !== exp_bin || err !== exp_err) begin
         errors++;
         $display("FAIL %s result: bcd=%h bin=%0d err=%b required bcd=%h bin=%0d err=%b",
                  name, bcd, bin, err, exp_bcd, exp_bin, exp_err);
      end
      tick();  // edge k+3
      checks++;
      if (ack !== 1'b0) begin
         errors++;
         $display("FAIL %s k+3: ack=%b required 0", name, ack);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 1'b0;
      repeat (2) tick();
      checks++;
      if (busy !== 1'b0 || ack !== 1'b0 || bcd !== 12'h000 || bin !== 10'd0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset: busy=%b ack=%b bcd=%h bin=%0d err=%b required all 0",
                  busy, ack, bcd, bin, err);
      end
      exp_bcd = '0;
      exp_bin = '0;
      exp_err = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      do_capture("basic_123", CODES[1], CODES[2], CODES[3]);
      checks++;
      if (bcd !== 12'h123 || bin !== 10'd123) begin
         errors++;
         $display("FAIL basic_const: bcd=%h bin=%0d required 123/123", bcd, bin);
      end
   endtask

   task automatic test_extremes();
      do_capture("max_999", CODES[9], CODES[9], CODES[9]);
      checks++;
      if (bin !== 10'd999) begin
         errors++;
         $display("FAIL max_const: bin=%0d required 999", bin);
      end
      do_capture("zero_000", CODES[0], CODES[0], CODES[0]);
   endtask

   task automatic test_illegal();
      do_capture("pre_123", CODES[1], CODES[2], CODES[3]);
      do_capture("illegal_units", CODES[1], CODES[2], 5'b01010);
      checks++;
      if (err !== 1'b1 || bcd !== 12'h123) begin
         errors++;
         $display("FAIL illegal_hold: err=%b bcd=%h required err=1 bcd=123", err, bcd);
      end
   endtask

   task automatic test_unstable();
      int ack_idx = -1;
      int ack_cnt = 0;
      d100 = CODES[4];
      d010 = CODES[5];
      for (int i = 0; i < 14; i++) begin
         d001 = (i % 2 == 0) ? CODES[1] : CODES[2];
         req  = (i == 4);
         tick();
         if (ack === 1'b1) begin
            ack_idx = i;
            ack_cnt++;
         end
      end
      req = 1'b0;
      exp_err = 1'b1;
      checks++;
      if (ack_idx != 8 || ack_cnt != 1) begin
         errors++;
         $display("FAIL unstable_ack: edge=%0d count=%0d required edge=8 count=1",
                  ack_idx, ack_cnt);
      end
      checks++;
      if (err !== exp_err || bcd !== exp_bcd || bin !== exp_bin) begin
         errors++;
         $display("FAIL unstable_result: err=%b bcd=%h bin=%0d required err=1 bcd=%h bin=%0d",
                  err, bcd, bin, exp_bcd, exp_bin);
      end
      do_capture("after_unstable", CODES[4], CODES[5], CODES[6]);
   endtask

   task automatic test_reset_mid();
      d100 = CODES[4];
      d010 = CODES[5];
      d001 = CODES[6];
      repeat (4) tick();
      req = 1'b1;
      tick();  // edge k, now in CAP
      req   = 1'b0;
      rst_n = 1'b0;
      tick();  // edge k+1 resets
      checks++;
      if (busy !== 1'b0 || ack !== 1'b0 || bcd !== 12'h000 || bin !== 10'd0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b ack=%b bcd=%h bin=%0d err=%b required all 0",
                  busy, ack, bcd, bin, err);
      end
      exp_bcd = '0;
      exp_bin = '0;
      exp_err = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet[%0d]: ack=%b busy=%b required 0/0", i, ack, busy);
         end
      end
      do_capture("after_reset", CODES[7], CODES[8], CODES[9]);
   endtask

   task automatic test_back_to_back();
      d100 = CODES[3];
      d010 = CODES[0];
      d001 = CODES[7];
      repeat (4) tick();
      model_update(d100, d010, d001);
      req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (ack !== ((i % 3) == 2)) begin
            errors++;
            $display("FAIL b2b_ack[%0d]: ack=%b required %b", i, ack, (i % 3) == 2);
         end
      end
      req = 1'b0;
      checks++;
      if (bin !== exp_bin || bcd !== exp_bcd || err !== exp_err) begin
         errors++;
         $display("FAIL b2b_result: bcd=%h bin=%0d err=%b required bcd=%h bin=%0d err=%b",
                  bcd, bin, err, exp_bcd, exp_bin, exp_err);
      end
      repeat (2) tick();
   endtask

   task automatic test_random();
      logic [4:0] h, t, u;
      for (int n = 0; n < 30; n++) begin
         h = CODES[$urandom_range(0, 9)];
         t = CODES[$urandom_range(0, 9)];
         u = CODES[$urandom_range(0, 9)];
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 2))
               0: h = rand_illegal();
               1: t = rand_illegal();
               default: u = rand_illegal();
            endcase
         end
         do_capture($sformatf("random_%0d", n), h, t, u);
      end
   endtask

`ifdef AUTO_SAMPLE_EN
   task automatic test_auto();
      int last = -1;
      int acks = 0;
      d100 = CODES[4];
      d010 = CODES[5];
      d001 = CODES[6];
      req  = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (ack === 1'b1) begin
            acks++;
            checks++;
            if (bin !== 10'd456 || err !== 1'b0) begin
               errors++;
               $display("FAIL auto_result: bin=%0d err=%b required 456/0", bin, err);
            end
            if (last >= 0) begin
               checks++;
               if (i - last != 8) begin
                  errors++;
                  $display("FAIL auto_period: gap=%0d required 8", i - last);
               end
            end
            last = i;
         end
      end
      checks++;
      if (acks < 6) begin
         errors++;
         $display("FAIL auto_count: acks=%0d required >=6", acks);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      req   = 1'b0;
      d100  = '0;
      d010  = '0;
      d001  = '0;
      test_reset();
`ifdef AUTO_SAMPLE_EN
      test_auto();
`else
      test_basic();
      test_extremes();
      test_illegal();
      test_unstable();
      test_reset_mid();
      test_back_to_back();
      test_random();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
